muldiv: RTL and testbench
=========================

MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; SHALL be a power of two, 8 or more.
REQ-002 Parameter UNROLL, default 1: result bits resolved per CALC cycle; SHALL be 1, 2 or 4 and divide XLEN.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the operation on op/a/b/rd_in is offered.
REQ-006 Port in_ready, output, 1 bit: the unit accepts an operation this cycle.
REQ-007 Port op, input, 3 bits: RV M funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port a, input, XLEN bits: rs1 operand.
REQ-009 Port b, input, XLEN bits: rs2 operand.
REQ-010 Port rd_in, input, 5 bits: destination tag, returned unchanged on rd_out.
REQ-011 Port flush, input, 1 bit: abandons any operation in flight.
REQ-012 Port out_valid, output, 1 bit: result and rd_out are valid.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 Port result, output, XLEN bits: operation result.
REQ-015 Port rd_out, output, 5 bits: tag of the result.
REQ-016 Port busy, output, 1 bit: high whenever state is not IDLE; drives decode stall.

Function
REQ-017 The FSM SHALL have three states, IDLE, CALC and DONE; in_ready SHALL equal (state==IDLE) AND NOT flush.
REQ-018 An operation SHALL be accepted on the edge where in_valid and in_ready are both high; op, operand magnitudes, sign flags and rd_in SHALL be latched on that edge.
REQ-019 Accepting a normal operation SHALL move IDLE->CALC; CALC SHALL last exactly XLEN/UNROLL cycles and then go to DONE.
REQ-020 Result latency from the accept edge to out_valid high SHALL be XLEN/UNROLL+1 cycles (33 for the defaults).
REQ-021 DIV/DIVU/REM/REMU with b==0 SHALL go IDLE->DONE directly (out_valid one cycle after accept) with quotient all-ones and remainder equal to a.
REQ-022 DIV/REM with a==most-negative and b==-1 SHALL go IDLE->DONE directly with quotient a and remainder 0.
REQ-023 Multiplication SHALL be radix-2^UNROLL shift-add on magnitudes into a 2*XLEN product; MUL returns the low half, MULH/MULHSU/MULHU return the high half.
REQ-024 Signedness SHALL be: MULH both operands signed; MULHSU a signed and b unsigned; MULHU and MUL unsigned, with MUL's low half identical for every signedness.
REQ-025 Division SHALL be restoring, UNROLL quotient bits per cycle, on magnitudes; the quotient sign SHALL be sign(a) XOR sign(b) and the remainder SHALL take the sign of a.
REQ-026 Sign correction SHALL be applied on the final CALC edge, so result is stable and final throughout DONE.
REQ-027 In DONE, out_valid SHALL be high and result/rd_out held constant until out_ready is high; out_valid AND out_ready SHALL move the FSM to IDLE.
REQ-028 A new operation SHALL be accepted no earlier than the cycle after DONE exits; there SHALL be no same-cycle handoff.
REQ-029 flush high SHALL force IDLE on the next edge from any state, deasserting out_valid; flush overrides a simultaneous in_valid or out_ready.
REQ-030 Inputs SHALL be ignored outside IDLE; op/a/b changing mid-operation SHALL NOT affect the result.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, out_valid 0, busy 0, result 0, rd_out 0 and clear the iteration counter; in_ready SHALL go high once reset_n is released.
REQ-032 Reset asserted mid-CALC or in DONE SHALL discard the operation with no result ever presented.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op encodings, the state enumeration and the UNROLL legality check; the CPU decode SHALL import the op encodings from it.
REQ-034 The block SHALL be a single module with no sub-module; the per-cycle step SHALL be a combinational loop of UNROLL iterations inside it.

Verification
REQ-035 MUL, a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, out_valid on cycle 33 after accept, rd_out equal to rd_in.
REQ-036 MULH, a=b=0x80000000 -> 0x40000000; MULHU, a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU, a=-1, b=2 -> 0xFFFFFFFF.
REQ-037 DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, the latter with out_valid 1 cycle after accept.
REQ-038 DIV 0x80000000/-1 -> 0x80000000 and REM of the same -> 0, both with 1-cycle latency.
REQ-039 Hold out_ready low 5 cycles in DONE -> result stable; flush at CALC cycle 10 -> IDLE next edge, no out_valid, next op correct; reset_n pulsed low in DONE -> out_valid 0 immediately.
REQ-040 Rerun REQ-035 to REQ-038 with XLEN=32 and UNROLL=4 -> identical results with latency 9.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op
// encodings, FSM state enumeration and the parameter legality check.
package muldiv_pkg;

   // RV M-extension funct3 encodings, also imported by the CPU decoder
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // XLEN: power of two, at least 8. UNROLL: 1, 2 or 4 and divides XLEN.
   function automatic bit unroll_ok(input int xlen, input int unroll);
      bit ok;
      ok = (unroll == 1) || (unroll == 2) || (unroll == 4);
      ok = ok && (xlen >= 8) && ((xlen & (xlen - 1)) == 0);
      ok = ok && ((xlen % unroll) == 0);
      return ok;
   endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on magnitudes, UNROLL result bits per CALC cycle, sign fix-up
// on the final CALC edge.
// Ports: clk, reset_n (async, active low); in_valid/in_ready with
// op/a/b/rd_in; flush; out_valid/out_ready with result/rd_out; busy.
module muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            busy
);

   localparam int STEPS = XLEN / UNROLL;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   if (!unroll_ok(XLEN, UNROLL)) begin : g_bad_param
      $error("muldiv: illegal XLEN/UNROLL combination");
   end

   state_e          state;
   logic [CW-1:0]   cnt;
   op_e             op_q;
   logic            neg_q;
   logic            neg_r_q;
   logic [XLEN-1:0] m_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] result_q;
   logic [4:0]      rd_q;

   // ---- accept-side decode ----
   op_e             op_i;
   logic            a_sgn;
   logic            b_sgn;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] spec_res;

   assign op_i = op_e'(op);

   always_comb begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      unique case (op_i)
         OP_MULH, OP_DIV, OP_REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         OP_MULHSU: a_sgn = 1'b1;
         default: ;
      endcase
   end

   assign a_neg = a_sgn & a[XLEN-1];
   assign b_neg = b_sgn & b[XLEN-1];
   assign mag_a = a_neg ? -a : a;
   assign mag_b = b_neg ? -b : b;

   // Corner cases resolved at accept time, bypassing CALC
   assign div_zero = op[2] && (b == '0);
   assign div_ovf  = op[2] && !op[0]
                  && (a == MIN_NEG) && (b == '1);

   always_comb begin
      if (div_zero)
         spec_res = op[1] ? a : '1;
      else
         spec_res = op[1] ? '0 : a;
   end

   // ---- per-cycle step: UNROLL iterations ----
   // Multiply: {hi,lo} holds partial product, lo starts as multiplier.
   // Divide:   hi is the partial remainder, lo shifts dividend out and
   //           quotient bits in.
   logic [XLEN-1:0] h_n;
   logic [XLEN-1:0] l_n;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   t;
   logic            qb;

   always_comb begin
      h_n = hi_q;
      l_n = lo_q;
      sum = '0;
      t   = '0;
      qb  = 1'b0;
      for (int i = 0; i < UNROLL; i++) begin
         if (op_q[2]) begin
            t  = {h_n, l_n[XLEN-1]};
            qb = (t >= {1'b0, m_q});
            if (qb)
               t = t - {1'b0, m_q};
            h_n = t[XLEN-1:0];
            l_n = {l_n[XLEN-2:0], qb};
         end else begin
            sum = {1'b0, h_n}
                + (l_n[0] ? {1'b0, m_q} : '0);
            l_n = {sum[0], l_n[XLEN-1:1]};
            h_n = sum[XLEN:1];
         end
      end
   end

   // ---- final sign correction ----
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   fin_res;

   always_comb begin
      prod   = {h_n, l_n};
      prod_s = neg_q ? -prod : prod;
      if (!op_q[2])
         fin_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0]
                                    : prod_s[2*XLEN-1:XLEN];
      else if (op_q[1])
         fin_res = neg_r_q ? -h_n : h_n;
      else
         fin_res = neg_q ? -l_n : l_n;
   end

   // ---- FSM and datapath registers ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         neg_r_q  <= 1'b0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q    <= op_i;
                  rd_q    <= rd_in;
                  neg_q   <= a_neg ^ b_neg;
                  neg_r_q <= a_neg;
                  cnt     <= '0;
                  if (div_zero || div_ovf) begin
                     result_q <= spec_res;
                     state    <= S_DONE;
                  end else begin
                     hi_q  <= '0;
                     lo_q  <= op[2] ? mag_a : mag_b;
                     m_q   <= op[2] ? mag_b : mag_a;
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               hi_q <= h_n;
               lo_q <= l_n;
               if (cnt == LAST) begin
                  cnt      <= '0;
                  result_q <= fin_res;
                  state    <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE) && !flush;
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);
   assign result    = result_q;
   assign rd_out    = rd_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: two instances (UNROLL=1 and UNROLL=4)
// driven in lockstep, checked against a plain-arithmetic reference.
module tb_muldiv;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        flush;
   logic        out_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd_in;
   logic [1:0]  in_ready;
   logic [1:0]  out_valid;
   logic [1:0]  busy;
   logic [31:0] res [2];
   logic [4:0]  rdo [2];

   int   checks;
   int   failures;
   int   cyc;
   int   acc [2];
   bit   seen [2];
   logic [31:0] held_r [2];
   logic [4:0]  held_d [2];
   bit   hold;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e;
   bit   has;
   vec_t dv [10];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      muldiv #(
         .XLEN  (32),
         .UNROLL((g == 0) ? 1 : 4)
      ) u_dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .in_valid (in_valid),
         .in_ready (in_ready[g]),
         .op       (op),
         .a        (a),
         .b        (b),
         .rd_in    (rd_in),
         .flush    (flush),
         .out_valid(out_valid[g]),
         .out_ready(out_ready),
         .result   (res[g]),
         .rd_out   (rdo[g]),
         .busy     (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: RV M semantics with plain 64-bit arithmetic
   function automatic bit special(input logic [2:0] o,
                                  input logic [31:0] x,
                                  input logic [31:0] y);
      return o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000
                                 && y == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] model(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      longint          sx;
      longint          sy;
      longint unsigned ux;
      longint unsigned uy;
      logic [63:0]     p;
      bit              ovf;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = {32'd0, x};
      uy  = {32'd0, y};
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         3'd0: begin p = ux * uy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * longint'(uy); return p[63:32]; end
         3'd3: begin p = ux * uy; return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (ovf) return x;
            p = sx / sy;
            return p[31:0];
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (ovf) return 32'd0;
            p = sx % sy;
            return p[31:0];
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Monitor: samples on the falling edge
   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < 2; k++) begin
            if (in_valid && in_ready[k])
               acc[k] = cyc;
            if (out_valid[k]) begin
               if (!seen[k]) begin
                  has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                  chk($sformatf("u%0d expected_output", k), 64'(has), 64'd1);
                  if (has) begin
                     e = (k == 0) ? q0[0] : q1[0];
                     chk($sformatf("u%0d result", k), 64'(res[k]), 64'(e.res));
                     chk($sformatf("u%0d rd_out", k), 64'(rdo[k]), 64'(e.rd));
                     chk($sformatf("u%0d latency", k), 64'(cyc - acc[k]), 64'(e.lat));
                  end
                  seen[k]   = 1'b1;
                  held_r[k] = res[k];
                  held_d[k] = rdo[k];
               end else begin
                  chk($sformatf("u%0d held_result", k), 64'(res[k]), 64'(held_r[k]));
                  chk($sformatf("u%0d held_rd", k), 64'(rdo[k]), 64'(held_d[k]));
               end
               if (out_ready) begin
                  seen[k] = 1'b0;
                  if (k == 0 && q0.size() > 0) void'(q0.pop_front());
                  if (k == 1 && q1.size() > 0) void'(q1.pop_front());
               end
            end
         end
      end
   end

   // Consumer back-pressure
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] r,
                        input logic [1:0] mask);
      int   n;
      exp_t ex;
      n = 0;
      while (in_ready != 2'b11 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) chk("issue_timeout", 64'(in_ready), 64'd3);
      ex.res = r;
      ex.rd  = 5'($urandom);
      if (mask[0]) begin
         ex.lat = special(o, x, y) ? 1 : 33;
         q0.push_back(ex);
      end
      if (mask[1]) begin
         ex.lat = special(o, x, y) ? 1 : 9;
         q1.push_back(ex);
      end
      in_valid = 1'b1;
      op       = o;
      a        = x;
      b        = y;
      rd_in    = ex.rd;
      @(posedge clk);
      #1;
      // Junk on the inputs while the unit is working must not matter
      in_valid = 1'b0;
      op       = 3'($urandom);
      a        = $urandom;
      b        = $urandom;
      rd_in    = 5'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q0.size() + q1.size() != 0 || busy != 2'b00) && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1000) chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (out_valid != 2'b11 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) chk("valid_timeout", 64'(out_valid), 64'd3);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      hold     = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      op       = '0;
      a        = '0;
      b        = '0;
      rd_in    = '0;
      seen[0]  = 1'b0;
      seen[1]  = 1'b0;
      acc[0]   = 0;
      acc[1]   = 0;
      reset_n  = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("u%0d reset out_valid", k), 64'(out_valid[k]), 64'd0);
         chk($sformatf("u%0d reset busy", k), 64'(busy[k]), 64'd0);
         chk($sformatf("u%0d reset result", k), 64'(res[k]), 64'd0);
         chk($sformatf("u%0d reset rd_out", k), 64'(rdo[k]), 64'd0);
      end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("in_ready after reset", 64'(in_ready), 64'd3);

      dv[0] = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
      dv[1] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      dv[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      dv[3] = '{3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
      dv[4] = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
      dv[5] = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
      dv[6] = '{3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF};
      dv[7] = '{3'd7, 32'd100, 32'd0, 32'd100};
      dv[8] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      dv[9] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 10; i++)
         issue(dv[i].op, dv[i].a, dv[i].b, dv[i].r, 2'b11);
      wait_idle();

      // Flush with in_valid in IDLE: nothing accepted
      flush    = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_idle busy", 64'(busy), 64'd0);
      chk("flush_idle out_valid", 64'(out_valid), 64'd0);

      // Flush at CALC cycle 10 (UNROLL=4 copy is already in DONE)
      hold      = 1'b1;
      out_ready = 1'b0;
      ra = $urandom;
      rb = $urandom;
      issue(3'd1, ra, rb, model(3'd1, ra, rb), 2'b10);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush out_valid", 64'(out_valid), 64'd0);
      chk("flush busy", 64'(busy), 64'd0);
      q1.delete();
      seen[1] = 1'b0;
      hold    = 1'b0;
      ra = 32'hFFFF_FF85;
      rb = 32'd9;
      issue(3'd4, ra, rb, model(3'd4, ra, rb), 2'b11);
      wait_idle();

      // Hold out_ready low 5 cycles in DONE
      hold      = 1'b1;
      out_ready = 1'b0;
      ra = $urandom;
      rb = $urandom;
      issue(3'd2, ra, rb, model(3'd2, ra, rb), 2'b11);
      wait_valid();
      repeat (5) @(posedge clk);
      #1 hold = 1'b0;
      wait_idle();

      // Reset pulse while in DONE
      hold      = 1'b1;
      out_ready = 1'b0;
      ra = $urandom;
      rb = 32'($urandom_range(1, 1000));
      issue(3'd7, ra, rb, model(3'd7, ra, rb), 2'b11);
      wait_valid();
      #1 reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("u%0d rst_done out_valid", k), 64'(out_valid[k]), 64'd0);
         chk($sformatf("u%0d rst_done busy", k), 64'(busy[k]), 64'd0);
         chk($sformatf("u%0d rst_done result", k), 64'(res[k]), 64'd0);
      end
      q0.delete();
      q1.delete();
      seen[0] = 1'b0;
      seen[1] = 1'b0;
      #3 reset_n = 1'b1;
      hold = 1'b0;
      @(posedge clk);
      #1;
      chk("post_reset in_ready", 64'(in_ready), 64'd3);

      for (int i = 0; i < 60; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = pick();
         rb = pick();
         issue(ro, ra, rb, model(ro, ra, rb), 2'b11);
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
